// File: rtl/bus_3m8s.sv
// Shared single-layer bus: 3 masters, 8 slaves, registered fixed-priority arbiter
// with bus parking on m0 and a one-cycle registered read-data return path.
module bus_3m8s #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_dout,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_dout,
  input  logic          m2_req,
  input  logic          m2_wr,
  input  logic [AW-1:0] m2_address,
  input  logic [DW-1:0] m2_dout,
  input  logic [DW-1:0] s0_dout,
  input  logic [DW-1:0] s1_dout,
  input  logic [DW-1:0] s2_dout,
  input  logic [DW-1:0] s3_dout,
  input  logic [DW-1:0] s4_dout,
  input  logic [DW-1:0] s5_dout,
  input  logic [DW-1:0] s6_dout,
  input  logic [DW-1:0] s7_dout,
  output logic          m0_grant,
  output logic          m1_grant,
  output logic          m2_grant,
  output logic [DW-1:0] m_din,
  output logic [7:0]    s_sel,
  output logic [AW-1:0] s_address,
  output logic          s_wr,
  output logic [DW-1:0] s_din
);

  typedef enum logic [1:0] {StGnt0, StGnt1, StGnt2} state_e;

  state_e        state_q, state_d, pick;
  logic          own_req, own_wr;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_dout;
  logic [7:0]    sel_q;
  logic [DW-1:0] s_dout [8];

  // Candidate for the next owner when the current owner releases; idle parks on m0.
  always_comb begin
    pick = StGnt0;
    if (m0_req)      pick = StGnt0;
    else if (m1_req) pick = StGnt1;
    else if (m2_req) pick = StGnt2;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StGnt0:  if (!m0_req) state_d = pick;
      StGnt1:  if (!m1_req) state_d = pick;
      StGnt2:  if (!m2_req) state_d = pick;
      default: state_d = StGnt0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StGnt0;
      sel_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      sel_q   <= s_sel;
    end
  end

  assign m0_grant = (state_q == StGnt0);
  assign m1_grant = (state_q == StGnt1);
  assign m2_grant = (state_q == StGnt2);

  always_comb begin
    own_req  = m0_req;
    own_wr   = m0_wr;
    own_addr = m0_address;
    own_dout = m0_dout;
    unique case (state_q)
      StGnt1: begin
        own_req  = m1_req;
        own_wr   = m1_wr;
        own_addr = m1_address;
        own_dout = m1_dout;
      end
      StGnt2: begin
        own_req  = m2_req;
        own_wr   = m2_wr;
        own_addr = m2_address;
        own_dout = m2_dout;
      end
      default: ;
    endcase
  end

  assign s_address = own_addr;
  assign s_din     = own_dout;
  assign s_wr      = own_wr & own_req;

  always_comb begin
    s_sel = 8'h00;
    if (own_req) s_sel[own_addr[AW-1:AW-3]] = 1'b1;
  end

  assign s_dout[0] = s0_dout;
  assign s_dout[1] = s1_dout;
  assign s_dout[2] = s2_dout;
  assign s_dout[3] = s3_dout;
  assign s_dout[4] = s4_dout;
  assign s_dout[5] = s5_dout;
  assign s_dout[6] = s6_dout;
  assign s_dout[7] = s7_dout;

  // sel_q is one-hot or zero, so an OR-reduction acts as the return mux.
  always_comb begin
    m_din = '0;
    for (int y = 0; y < 8; y++) begin
      if (sel_q[y]) m_din = m_din | s_dout[y];
    end
  end

endmodule

// File: tb/tb_bus_3m8s.sv
// Self-checking bench for bus_3m8s: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_bus_3m8s;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req, wr;
  logic [7:0]  addr  [3];
  logic [31:0] mdout [3];
  logic [31:0] sdout [8];
  logic        g0, g1, g2, s_wr;
  logic [31:0] m_din, s_din;
  logic [7:0]  s_sel, s_address;

  int tests = 0;
  int fails = 0;
  int owner;       // model: index of master holding the bus
  int last_slave;  // model: slave addressed last cycle, -1 when none

  always #5 clk = ~clk;

  bus_3m8s dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(req[0]), .m0_wr(wr[0]), .m0_address(addr[0]), .m0_dout(mdout[0]),
    .m1_req(req[1]), .m1_wr(wr[1]), .m1_address(addr[1]), .m1_dout(mdout[1]),
    .m2_req(req[2]), .m2_wr(wr[2]), .m2_address(addr[2]), .m2_dout(mdout[2]),
    .s0_dout(sdout[0]), .s1_dout(sdout[1]), .s2_dout(sdout[2]), .s3_dout(sdout[3]),
    .s4_dout(sdout[4]), .s5_dout(sdout[5]), .s6_dout(sdout[6]), .s7_dout(sdout[7]),
    .m0_grant(g0), .m1_grant(g1), .m2_grant(g2),
    .m_din(m_din), .s_sel(s_sel), .s_address(s_address), .s_wr(s_wr), .s_din(s_din)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model, advance the model, move to next negedge.
  task automatic cycle();
    logic [7:0]  e_sel;
    logic [31:0] e_mdin;
    #1;
    e_sel  = req[owner] ? (8'd1 << addr[owner][7:5]) : 8'd0;
    e_mdin = (last_slave < 0) ? 32'd0 : sdout[last_slave];
    check("m0_grant", g0, owner == 0);
    check("m1_grant", g1, owner == 1);
    check("m2_grant", g2, owner == 2);
    check("s_sel", s_sel, e_sel);
    check("s_address", s_address, addr[owner]);
    check("s_din", s_din, mdout[owner]);
    check("s_wr", s_wr, wr[owner] & req[owner]);
    check("m_din", m_din, e_mdin);
    last_slave = req[owner] ? int'(addr[owner][7:5]) : -1;
    if (!req[owner]) begin
      owner = 0;
      for (int i = 2; i >= 0; i--) if (req[i]) owner = i;
    end
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic r, input logic w, input logic [7:0] a,
                       input logic [31:0] d);
    req[m] = r; wr[m] = w; addr[m] = a; mdout[m] = d;
  endtask

  initial begin
    reset_n = 1'b0;
    req = '0; wr = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = 8'h00; mdout[i] = 32'h0; end
    sdout[0] = 32'hAAAAAAAA; sdout[1] = 32'hBBBBBBBB; sdout[2] = 32'hCCCCCCCC;
    sdout[3] = 32'hDDDDDDDD; sdout[4] = 32'hEEEEEEEE; sdout[5] = 32'hFFFFFFFF;
    sdout[6] = 32'h12345678; sdout[7] = 32'h87654321;
    addr[0] = 8'h5A; mdout[0] = 32'hCAFE0000;
    owner = 0; last_slave = -1;
    repeat (2) @(negedge clk);
    #1;
    check("rst m0_grant", g0, 1'b1);
    check("rst m1_grant", g1, 1'b0);
    check("rst m2_grant", g2, 1'b0);
    check("rst s_sel", s_sel, 8'h00);
    check("rst s_wr", s_wr, 1'b0);
    check("rst m_din", m_din, 32'h0);
    check("rst s_address", s_address, 8'h5A);
    check("rst s_din", s_din, 32'hCAFE0000);
    @(negedge clk);
    reset_n = 1'b1;

    // m0 write to slave 0
    drive(0, 1, 1, 8'h01, 32'h11111111);
    #1;
    check("t2 s_sel", s_sel, 8'h01);
    check("t2 s_wr", s_wr, 1'b1);
    check("t2 s_address", s_address, 8'h01);
    check("t2 s_din", s_din, 32'h11111111);
    cycle();
    // m0 releases, m1 reads slave 1
    drive(0, 0, 0, 8'h01, 32'h0);
    drive(1, 1, 0, 8'h21, 32'h0);
    #1;
    check("t2 m_din", m_din, 32'hAAAAAAAA);
    check("t3 still m0", g0, 1'b1);
    cycle();
    #1;
    check("t3 m1_grant", g1, 1'b1);
    check("t3 s_sel", s_sel, 8'h02);
    check("t3 s_wr", s_wr, 1'b0);
    cycle();
    // m1 releases, m2 writes slave 2
    drive(1, 0, 0, 8'h21, 32'h0);
    drive(2, 1, 1, 8'h41, 32'h33333333);
    #1;
    check("t3 m_din", m_din, 32'hBBBBBBBB);
    cycle();
    #1;
    check("t4 m2_grant", g2, 1'b1);
    check("t4 s_sel", s_sel, 8'h04);
    check("t4 s_din", s_din, 32'h33333333);
    cycle();
    // m2 releases while m0 and m1 both request: m0 wins
    drive(2, 0, 0, 8'h41, 32'h0);
    drive(0, 1, 0, 8'hC1, 32'h0);
    drive(1, 1, 0, 8'h21, 32'h0);
    #1;
    check("t4 m_din", m_din, 32'hCCCCCCCC);
    cycle();
    #1;
    check("t5 m0_grant", g0, 1'b1);
    check("t6 s_sel", s_sel, 8'h40);
    cycle();
    #1;
    check("t6 m_din", m_din, 32'h12345678);
    check("t5 m1 waits", g1, 1'b0);
    cycle();
    drive(0, 0, 0, 8'hC1, 32'h0);
    cycle();
    #1;
    check("t5 m1 after m0", g1, 1'b1);
    cycle();
    req = '0;
    cycle();
    #1;
    check("t6 park m0", g0, 1'b1);
    check("t6 s_sel idle", s_sel, 8'h00);
    cycle();

    // reset in the middle of an m1 transfer
    drive(1, 1, 0, 8'hE0, 32'h0);
    cycle();
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid-rst m0_grant", g0, 1'b1);
    check("mid-rst m1_grant", g1, 1'b0);
    check("mid-rst m_din", m_din, 32'h0);
    owner = 0; last_slave = -1;
    @(negedge clk);
    reset_n = 1'b1;
    cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(3) == 0) req[i] = ~req[i];
        wr[i]    = 1'($urandom);
        if ($urandom_range(2) == 0) addr[i] = 8'($urandom);
        mdout[i] = $urandom;
      end
      for (int y = 0; y < 8; y++) sdout[y] = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
